// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares one single-ported data memory between the core and a DMA master,
// core first, with a starvation limit that eventually forces a DMA grant.
module data_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  input  logic              core_write,
  input  logic              core_read,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ready,
  input  logic [DATA_W-1:0] m_rdata
);
  typedef enum logic [1:0] {IDLE, CORE_BUSY, DMA_BUSY} state_t;
  state_t state, state_nx;
  logic [3:0] starve_cnt;
  logic [DATA_W-1:0] core_hold, dma_hold;
  logic core_req, core_done, dma_done, grant_core, grant_dma;
  assign core_req   = core_read | core_write;
  assign core_done  = state == CORE_BUSY && m_ready;
  assign dma_done   = state == DMA_BUSY && m_ready;
  // Core wins a contested IDLE cycle until it has starved the DMA STARVE_LIMIT times in a row.
  assign grant_core = state == IDLE && core_req && !(dma_req && starve_cnt >= 4'(STARVE_LIMIT));
  assign grant_dma  = state == IDLE && dma_req && !grant_core;
  assign m_req      = state != IDLE;
  assign core_stall = core_req && !core_done;
  assign core_rdata = core_done && !m_we ? m_rdata : core_hold;
  assign dma_gnt    = dma_done;
  assign dma_rdata  = dma_done ? m_rdata : dma_hold;
  always_comb begin
    state_nx = state;
    if (grant_core) state_nx = CORE_BUSY;
    else if (grant_dma) state_nx = DMA_BUSY;
    else if (core_done || dma_done) state_nx = IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      m_we       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      core_hold  <= '0;
      dma_hold   <= '0;
    end else begin
      state <= state_nx;
      if (grant_core) begin
        starve_cnt <= dma_req ? starve_cnt + 4'd1 : 4'd0;
        m_we       <= core_write;
        m_addr     <= core_addr;
        m_wdata    <= core_wdata;
      end
      if (grant_dma) begin
        starve_cnt <= '0;
        m_we       <= dma_we;
        m_addr     <= dma_addr;
        m_wdata    <= dma_wdata;
      end
      if (core_done && !m_we) core_hold <= m_rdata;
      if (dma_done) dma_hold <= m_rdata;
    end
  end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: bench with a wait-state memory model and an in-order transaction scoreboard.
module tb_data_mem_arbiter;
  logic clk = 0, reset = 1;
  logic [31:0] core_addr = 0, core_wdata = 0, core_rdata;
  logic core_write = 0, core_read = 0, core_stall;
  logic dma_req = 0, dma_we = 0, dma_gnt;
  logic [31:0] dma_addr = 0, dma_wdata = 0, dma_rdata;
  logic m_req, m_we, m_ready = 0;
  logic [31:0] m_addr, m_wdata, m_rdata = 0;
  int checks = 0, errors = 0;
  int mem_wait = 0, wcnt = 0;
  logic [31:0] rd_word = 0;
  typedef struct {logic we; logic [31:0] addr; logic [31:0] wdata;} txn_t;
  txn_t exp_q[$];
  txn_t sb_t;

  always #5 clk = ~clk;

  data_mem_arbiter dut (
    .clk(clk), .reset(reset), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_write(core_write), .core_read(core_read), .core_rdata(core_rdata),
    .core_stall(core_stall), .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .m_req(m_req),
    .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_ready(m_ready), .m_rdata(m_rdata)
  );

  // Memory answers after mem_wait busy cycles; every completion is matched against the scoreboard.
  always @(negedge clk) begin
    if (reset || !m_req) begin
      m_ready = 0;
      wcnt = 0;
    end else begin
      m_ready = (wcnt == mem_wait);
      m_rdata = m_ready ? rd_word : ~rd_word;
      wcnt++;
    end
    if (m_req && m_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got we=%b addr=%h, no transaction expected", m_we, m_addr);
      end else begin
        sb_t = exp_q.pop_front();
        if (m_we !== sb_t.we || m_addr !== sb_t.addr || (sb_t.we && m_wdata !== sb_t.wdata)) begin
          errors++;
          $display("FAIL sb_txn got we=%b addr=%h wdata=%h, want we=%b addr=%h wdata=%h",
                   m_we, m_addr, m_wdata, sb_t.we, sb_t.addr, sb_t.wdata);
        end
      end
    end
  end

  task automatic step(); @(posedge clk); #1; endtask
  task automatic look(); @(negedge clk); #1; endtask

  task automatic test_reset();
    reset = 1; core_read = 1;
    step(); step(); look();
    checks++;
    if (m_req !== 0 || m_we !== 0 || m_addr !== 0 || m_wdata !== 0) begin
      errors++; $display("FAIL reset_mem got req=%b we=%b addr=%h wdata=%h, want all 0", m_req, m_we, m_addr, m_wdata);
    end
    checks++;
    if (dma_gnt !== 0 || dma_rdata !== 0 || core_rdata !== 0) begin
      errors++; $display("FAIL reset_out got gnt=%b dma_rdata=%h core_rdata=%h, want 0", dma_gnt, dma_rdata, core_rdata);
    end
    checks++;
    if (core_stall !== 1) begin errors++; $display("FAIL reset_stall_hi got %b want 1", core_stall); end
    step(); core_read = 0; look();
    checks++;
    if (core_stall !== 0) begin errors++; $display("FAIL reset_stall_lo got %b want 0", core_stall); end
    step(); reset = 0; look();
  endtask

  task automatic test_core_load();
    step(); mem_wait = 0; rd_word = 32'hDEADBEEF;
    exp_q.push_back(txn_t'{we: 1'b0, addr: 32'h100, wdata: 32'h0});
    core_addr = 32'h100; core_read = 1;
    look();
    checks++;
    if (core_stall !== 1 || m_req !== 0) begin errors++; $display("FAIL load_n got stall=%b req=%b, want 1 0", core_stall, m_req); end
    step(); look();
    checks++;
    if (m_req !== 1 || m_addr !== 32'h100 || m_we !== 0) begin errors++; $display("FAIL load_req got req=%b addr=%h we=%b", m_req, m_addr, m_we); end
    checks++;
    if (core_stall !== 0 || core_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL load_data got stall=%b rdata=%h, want 0 deadbeef", core_stall, core_rdata);
    end
    step(); core_read = 0; look();
    checks++;
    if (core_rdata !== 32'hDEADBEEF || m_req !== 0) begin errors++; $display("FAIL load_hold got rdata=%h req=%b", core_rdata, m_req); end
  endtask

  task automatic test_core_store();
    int n_stall;
    step(); mem_wait = 3; rd_word = 32'hFFFF0000;
    exp_q.push_back(txn_t'{we: 1'b1, addr: 32'h40, wdata: 32'h12345678});
    core_addr = 32'h40; core_wdata = 32'h12345678; core_write = 1; core_read = 1;
    look(); n_stall = core_stall ? 1 : 0;
    for (int k = 0; k < 4; k++) begin
      step(); look();
      checks++;
      if (m_req !== 1 || m_we !== 1 || m_addr !== 32'h40 || m_wdata !== 32'h12345678) begin
        errors++; $display("FAIL store_hold[%0d] got req=%b we=%b addr=%h wdata=%h", k, m_req, m_we, m_addr, m_wdata);
      end
      if (core_stall) n_stall++;
    end
    checks++;
    if (n_stall !== 4) begin errors++; $display("FAIL store_stall_cycles got %0d want 4", n_stall); end
    checks++;
    if (core_stall !== 0 || core_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL store_done got stall=%b rdata=%h, want 0 deadbeef", core_stall, core_rdata);
    end
    step(); core_write = 0; core_read = 0; look();
  endtask

  task automatic test_dma_read();
    int gnts = 0, stalls = 0;
    step(); mem_wait = 1; rd_word = 32'hA5A5A5A5;
    exp_q.push_back(txn_t'{we: 1'b0, addr: 32'h200, wdata: 32'h0});
    dma_req = 1; dma_we = 0; dma_addr = 32'h200;
    for (int k = 0; k < 6; k++) begin
      look();
      if (core_stall) stalls++;
      if (dma_gnt) begin
        gnts++; checks++;
        if (dma_rdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL dma_rdata got %h want a5a5a5a5", dma_rdata); end
      end
      step();
      if (gnts > 0) dma_req = 0;
    end
    look();
    checks++;
    if (gnts !== 1 || stalls !== 0) begin errors++; $display("FAIL dma_pulses got gnt=%0d stalls=%0d, want 1 0", gnts, stalls); end
    checks++;
    if (dma_rdata !== 32'hA5A5A5A5 || dma_gnt !== 0) begin errors++; $display("FAIL dma_hold got %h gnt=%b", dma_rdata, dma_gnt); end
  endtask

  task automatic test_starvation();
    int ci = 0, di = 0, done = 0;
    logic cdone, ddone;
    step(); mem_wait = 0; rd_word = 0;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(txn_t'{we: 1'b0, addr: 32'h1000 + 32'(4 * i), wdata: 32'h0});
      if (i == 3 || i == 7) exp_q.push_back(txn_t'{we: 1'b0, addr: 32'h2000 + (i == 7 ? 32'h4 : 32'h0), wdata: 32'h0});
    end
    core_read = 1; core_addr = 32'h1000; dma_req = 1; dma_we = 0; dma_addr = 32'h2000;
    for (int k = 0; k < 60 && done < 10; k++) begin
      look(); cdone = core_read && !core_stall; ddone = dma_gnt;
      step();
      if (cdone) begin ci++; done++; core_addr = 32'h1000 + 32'(4 * ci); end
      if (ddone) begin di++; done++; dma_addr = 32'h2000 + 32'(4 * di); end
    end
    core_read = 0; dma_req = 0;
    checks++;
    if (ci !== 8 || di !== 2) begin errors++; $display("FAIL starve_counts got core=%0d dma=%0d, want 8 2", ci, di); end
    checks++;
    if (exp_q.size() !== 0) begin errors++; $display("FAIL starve_left got %0d pending, want 0", exp_q.size()); end
    look();
  endtask

  task automatic test_core_during_dma();
    logic gseen = 0, stall_ok = 1, cd = 0;
    step(); mem_wait = 2; rd_word = 32'h5A5A0001;
    exp_q.push_back(txn_t'{we: 1'b0, addr: 32'h600, wdata: 32'h0});
    exp_q.push_back(txn_t'{we: 1'b0, addr: 32'h300, wdata: 32'h0});
    dma_req = 1; dma_we = 0; dma_addr = 32'h600;
    look();
    step(); core_read = 1; core_addr = 32'h300;
    for (int k = 0; k < 10 && !gseen; k++) begin
      look();
      if (!core_stall) stall_ok = 0;
      gseen = dma_gnt;
      step();
    end
    dma_req = 0;
    checks++;
    if (gseen !== 1 || stall_ok !== 1) begin errors++; $display("FAIL cdma_wait got gnt_seen=%b stall_held=%b, want 1 1", gseen, stall_ok); end
    look();
    checks++;
    if (core_stall !== 1 || m_req !== 0) begin errors++; $display("FAIL cdma_idle got stall=%b req=%b, want 1 0", core_stall, m_req); end
    step(); look();
    checks++;
    if (m_req !== 1 || m_addr !== 32'h300 || m_we !== 0) begin errors++; $display("FAIL cdma_grant got req=%b addr=%h we=%b", m_req, m_addr, m_we); end
    for (int k = 0; k < 10 && !cd; k++) begin step(); look(); cd = !core_stall; end
    checks++;
    if (cd !== 1 || core_rdata !== 32'h5A5A0001) begin errors++; $display("FAIL cdma_done got done=%b rdata=%h", cd, core_rdata); end
    step(); core_read = 0; look();
  endtask

  task automatic test_reset_mid();
    logic cd = 0;
    step(); mem_wait = 5; rd_word = 32'h0F0F0F0F;
    exp_q.push_back(txn_t'{we: 1'b0, addr: 32'h500, wdata: 32'h0});
    core_read = 1; core_addr = 32'h500;
    look(); step(); look();
    checks++;
    if (m_req !== 1) begin errors++; $display("FAIL rmid_busy got req=%b want 1", m_req); end
    step(); reset = 1; look();
    step(); look();
    checks++;
    if (m_req !== 0 || m_addr !== 0 || core_rdata !== 0 || dma_rdata !== 0 || core_stall !== 1) begin
      errors++; $display("FAIL rmid_reset got req=%b addr=%h crd=%h drd=%h stall=%b", m_req, m_addr, core_rdata, dma_rdata, core_stall);
    end
    step(); reset = 0; look();
    checks++;
    if (m_req !== 0) begin errors++; $display("FAIL rmid_idle got req=%b want 0", m_req); end
    step(); look();
    checks++;
    if (m_req !== 1 || m_addr !== 32'h500) begin errors++; $display("FAIL rmid_rearb got req=%b addr=%h", m_req, m_addr); end
    for (int k = 0; k < 15 && !cd; k++) begin step(); look(); cd = !core_stall; end
    checks++;
    if (cd !== 1 || core_rdata !== 32'h0F0F0F0F) begin errors++; $display("FAIL rmid_done got done=%b rdata=%h", cd, core_rdata); end
    step(); core_read = 0; look();
  endtask

  initial begin
    test_reset();
    test_core_load();
    test_core_store();
    test_dma_read();
    test_starvation();
    test_core_during_dma();
    test_reset_mid();
    checks++;
    if (exp_q.size() !== 0) begin errors++; $display("FAIL sb_pending got %0d want 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
